pc_sequencer: RTL and testbench

//  Fetch/decode/execute sequencer that drives the program_counter's load/enable/data inputs.

---
 rtl/pc_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/decode/execute sequencer driving the program counter
//
// Purpose:
//   Fetches the instruction at pc_out over a req/ready handshake and latches it.
//   NOP, JMP, JZ and HALT are resolved here. Every other opcode goes to the datapath
//   over an exec_start/exec_done handshake. The sequencer drives the program
//   counter's load/enable/data inputs.
//
// Optional feature (macro PC_SEQ_WATCHDOG_EN):
//   When defined, a watchdog counts cycles spent in FETCH and EXEC. If TIMEOUT
//   cycles pass without mem_ready/exec_done, err is set (sticky until reset) and the
//   sequencer moves to HALTED. When undefined, waits are unbounded and err is 0.
//
// Ports:
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous active-low reset
//   start       in   1   leave IDLE / resume from HALTED
//   pc_out      in   W   current PC from program_counter
//   pc_data     out  W   branch target (valid while pc_load is high, else 0)
//   pc_load     out  1   load pc_data into PC
//   pc_enable   out  1   increment PC
//   mem_req     out  1   instruction fetch request
//   mem_addr    out  W   fetch address (pc_out while mem_req is high, else 0)
//   mem_ready   in   1   fetch data valid
//   mem_rdata   in   IW  fetched instruction
//   zero_flag   in   1   datapath zero flag, used by JZ in DECODE
//   instr       out  IW  latched instruction
//   exec_start  out  1   one-cycle pulse starting the datapath
//   exec_done   in   1   datapath completion
//   busy        out  1   high outside IDLE and HALTED
//   halted      out  1   high in HALTED
//   err         out  1   watchdog timeout, sticky

module pc_sequencer #(
  parameter int W       = 4,
  parameter int IW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  pc_out,
  output logic [W-1:0]  pc_data,
  output logic          pc_load,
  output logic          pc_enable,
  output logic          mem_req,
  output logic [W-1:0]  mem_addr,
  input  logic          mem_ready,
  input  logic [IW-1:0] mem_rdata,
  input  logic          zero_flag,
  output logic [IW-1:0] instr,
  output logic          exec_start,
  input  logic          exec_done,
  output logic          busy,
  output logic          halted,
  output logic          err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_BRANCH  = 3'd4;
  localparam logic [2:0] S_ADVANCE = 3'd5;
  localparam logic [2:0] S_HALTED  = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_JZ   = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0] state;
  logic [2:0] next_state;
  logic [3:0] opcode;
  logic       exec_first;
  logic       wd_expire;

  assign opcode = instr[IW-1:IW-4];

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_FETCH;
      end
      S_FETCH: begin
        // A fetch completing in the same cycle the watchdog expires still wins.
        if (mem_ready)      next_state = S_DECODE;
        else if (wd_expire) next_state = S_HALTED;
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP:  next_state = S_ADVANCE;
          OP_JMP:  next_state = S_BRANCH;
          OP_JZ:   next_state = zero_flag ? S_BRANCH : S_ADVANCE;
          OP_HALT: next_state = S_HALTED;
          default: next_state = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (exec_done)      next_state = S_ADVANCE;
        else if (wd_expire) next_state = S_HALTED;
      end
      S_BRANCH:  next_state = S_FETCH;
      S_ADVANCE: next_state = S_FETCH;
      S_HALTED: begin
        // Resuming steps past the HALT instruction itself.
        if (start) next_state = S_ADVANCE;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      instr      <= '0;
      exec_first <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && mem_ready) instr <= mem_rdata;
      // Marks the first EXEC cycle so exec_start is a single pulse however long EXEC lasts.
      exec_first <= (next_state == S_EXEC) && (state != S_EXEC);
    end
  end

`ifdef PC_SEQ_WATCHDOG_EN
  // Counter holds the number of cycles already spent in the current FETCH/EXEC visit.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] wd_cnt;
  logic          wd_active;
  logic          err_q;

  assign wd_active = (state == S_FETCH) || (state == S_EXEC);
  assign wd_expire = wd_active && (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!wd_active || next_state != state) wd_cnt <= '0;
      else                                   wd_cnt <= wd_cnt + 1'b1;
      // FETCH/EXEC only reach HALTED through a watchdog expiry.
      if (wd_active && next_state == S_HALTED) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  assign mem_req    = (state == S_FETCH);
  assign mem_addr   = mem_req ? pc_out : '0;
  assign pc_load    = (state == S_BRANCH);
  assign pc_data    = pc_load ? instr[W-1:0] : '0;
  assign pc_enable  = (state == S_ADVANCE);
  assign exec_start = (state == S_EXEC) && exec_first;
  assign busy       = (state != S_IDLE) && (state != S_HALTED);
  assign halted     = (state == S_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer

module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pc_out;
  logic [3:0] pc_data;
  logic       pc_load;
  logic       pc_enable;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic       zero_flag;
  logic [7:0] instr;
  logic       exec_start;
  logic       exec_done;
  logic       busy;
  logic       halted;
  logic       err;

  int tests = 0;
  int fails = 0;

  logic [7:0] imem [16];
  logic       pc_force;
  logic [3:0] pc_force_val;
  logic [3:0] pc;

  always #5 clk = ~clk;

  // Program counter model sitting next to the sequencer.
  always @(posedge clk) begin
    if (pc_force)       pc <= pc_force_val;
    else if (pc_load)   pc <= pc_data;
    else if (pc_enable) pc <= pc + 4'd1;
  end

  assign pc_out    = pc;
  assign mem_rdata = imem[mem_addr];

  pc_sequencer #(.W(4), .IW(8), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pc_out     (pc_out),
    .pc_data    (pc_data),
    .pc_load    (pc_load),
    .pc_enable  (pc_enable),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .zero_flag  (zero_flag),
    .instr      (instr),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .busy       (busy),
    .halted     (halted),
    .err        (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [3:0] v);
    pc_force     = 1'b1;
    pc_force_val = v;
    tick();
    pc_force     = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b1;
    #3;
    tests++;
    if ({mem_req, pc_load, pc_enable, exec_start, busy, halted, err} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b exp 0000000", {mem_req, pc_load, pc_enable, exec_start, busy, halted, err});
    end
    tests++;
    if ({instr, pc_data, mem_addr} !== 16'h0) begin
      fails++;
      $display("FAIL reset_data got %h exp 0000", {instr, pc_data, mem_addr});
    end
    tick();
    tick();
    tests++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold_start got busy=%b mem_req=%b exp 0 0", busy, mem_req);
    end
    start = 1'b0;
    reset = 1'b1;
    set_pc(4'd3);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_start got busy=%b exp 0", busy);
    end
    pulse_start();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 4'd3 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_fetch got req=%b addr=%h busy=%b exp 1 3 1", mem_req, mem_addr, busy);
    end
  endtask

  task automatic test_nop;
    tick();
    tests++;
    if (instr !== 8'h07 || pc_enable !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL nop_decode got instr=%h en=%b req=%b exp 07 0 0", instr, pc_enable, mem_req);
    end
    tick();
    tests++;
    if (pc_enable !== 1'b1 || pc_load !== 1'b0) begin
      fails++;
      $display("FAIL nop_advance got en=%b ld=%b exp 1 0", pc_enable, pc_load);
    end
    tick();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 4'd4 || pc_enable !== 1'b0) begin
      fails++;
      $display("FAIL nop_next_fetch got req=%b addr=%h en=%b exp 1 4 0", mem_req, mem_addr, pc_enable);
    end
  endtask

  task automatic test_branch;
    tick();
    tick();
    tests++;
    if (pc_load !== 1'b1 || pc_data !== 4'hA || pc_enable !== 1'b0) begin
      fails++;
      $display("FAIL jmp_load got ld=%b data=%h en=%b exp 1 a 0", pc_load, pc_data, pc_enable);
    end
    tick();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 4'hA || pc_load !== 1'b0) begin
      fails++;
      $display("FAIL jmp_fetch got req=%b addr=%h ld=%b exp 1 a 0", mem_req, mem_addr, pc_load);
    end
    zero_flag = 1'b0;
    tick();
    tick();
    tests++;
    if (pc_enable !== 1'b1 || pc_load !== 1'b0) begin
      fails++;
      $display("FAIL jz_not_taken got en=%b ld=%b exp 1 0", pc_enable, pc_load);
    end
    tick();
    tests++;
    if (mem_addr !== 4'hB) begin
      fails++;
      $display("FAIL jz_nt_fetch got addr=%h exp b", mem_addr);
    end
    zero_flag = 1'b1;
    tick();
    tick();
    zero_flag = 1'b0;
    tests++;
    if (pc_load !== 1'b1 || pc_data !== 4'hD || pc_enable !== 1'b0) begin
      fails++;
      $display("FAIL jz_taken got ld=%b data=%h en=%b exp 1 d 0", pc_load, pc_data, pc_enable);
    end
    tick();
  endtask

  task automatic test_exec;
    int starts;
    tick();
    tick();
    tests++;
    if (exec_start !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL exec_start_pulse got start=%b busy=%b exp 1 1", exec_start, busy);
    end
    starts = 0;
    for (int i = 1; i <= 4; i++) begin
      start = (i == 2);
      tick();
      if (exec_start === 1'b1 || pc_enable === 1'b1 || busy !== 1'b1) starts++;
    end
    start = 1'b0;
    tests++;
    if (starts != 0) begin
      fails++;
      $display("FAIL exec_wait got %0d bad cycles exp 0", starts);
    end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    tests++;
    if (pc_enable !== 1'b1 || exec_start !== 1'b0) begin
      fails++;
      $display("FAIL exec_advance got en=%b start=%b exp 1 0", pc_enable, exec_start);
    end
    tick();
    tests++;
    if (mem_addr !== 4'hE) begin
      fails++;
      $display("FAIL exec_next_fetch got addr=%h exp e", mem_addr);
    end
    exec_done = 1'b1;
    tick();
    tick();
    tests++;
    if (exec_start !== 1'b1) begin
      fails++;
      $display("FAIL exec_fast_start got %b exp 1", exec_start);
    end
    tick();
    exec_done = 1'b0;
    tests++;
    if (pc_enable !== 1'b1) begin
      fails++;
      $display("FAIL exec_first_cycle_done got en=%b exp 1", pc_enable);
    end
    tick();
  endtask

  task automatic test_halt;
    int bad;
    tick();
    tick();
    tests++;
    if (halted !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL halt_state got halted=%b busy=%b req=%b exp 1 0 0", halted, busy, mem_req);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pc !== 4'hF || pc_enable !== 1'b0 || pc_load !== 1'b0 || halted !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL halt_frozen got %0d bad cycles exp 0", bad);
    end
    pulse_start();
    tests++;
    if (pc_enable !== 1'b1 || halted !== 1'b0) begin
      fails++;
      $display("FAIL resume_advance got en=%b halted=%b exp 1 0", pc_enable, halted);
    end
    mem_ready = 1'b0;
    tick();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 4'h0) begin
      fails++;
      $display("FAIL resume_wrap_fetch got req=%b addr=%h exp 1 0", mem_req, mem_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got req=%b busy=%b exp 0 0", mem_req, busy);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_watchdog;
    set_pc(4'd0);
    pulse_start();
    for (int i = 0; i < 14; i++) tick();
    tests++;
    if (mem_req !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL wd_before_limit got req=%b err=%b exp 1 0", mem_req, err);
    end
`ifdef PC_SEQ_WATCHDOG_EN
    tick();
    tests++;
    if (err !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL wd_expire got err=%b halted=%b req=%b exp 1 1 0", err, halted, mem_req);
    end
    pulse_start();
    tests++;
    if (err !== 1'b1 || pc_enable !== 1'b1) begin
      fails++;
      $display("FAIL wd_sticky got err=%b en=%b exp 1 1", err, pc_enable);
    end
`else
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (err !== 1'b0 || halted !== 1'b0 || mem_req !== 1'b1) begin
      fails++;
      $display("FAIL wait_forever got err=%b halted=%b req=%b exp 0 0 1", err, halted, mem_req);
    end
`endif
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    mem_ready    = 1'b1;
    zero_flag    = 1'b0;
    exec_done    = 1'b0;
    pc_force     = 1'b0;
    pc_force_val = 4'd0;
    pc           = 4'd0;
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    imem[3]  = 8'h07;
    imem[4]  = 8'h1A;
    imem[10] = 8'h25;
    imem[11] = 8'h2D;
    imem[13] = 8'h43;
    imem[14] = 8'h5C;
    imem[15] = 8'hF0;

    test_reset();
    test_nop();
    test_branch();
    test_exec();
    test_halt();
    test_watchdog();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
